// File: rtl/des_perm_pipe.sv
// Elastic DES bit-permutation pipeline: IP, FP, swap+FP or pass-through is selected
// per word, and the selected permutation is applied ahead of a STAGES-deep valid/ready register chain.
module des_perm_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [63:0]                      in_data_i,
    input  logic [1:0]                       in_mode_i,
    input  logic [TAG_W-1:0]                 in_tag_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [63:0]                      out_data_o,
    output logic [TAG_W-1:0]                 out_tag_o,
    output logic [$clog2(STAGES+1)-1:0]      count_o
);

    localparam int CNT_W = $clog2(STAGES + 1);

    // Row r of the IP output takes bits from the input column s(r) = 1,3,5,7,0,2,4,6.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        int          s;
        y = '0;
        for (int r = 0; r < 8; r++) begin
            s = (r < 4) ? (2 * r + 1) : (2 * r - 8);
            for (int c = 0; c < 8; c++) begin
                y[63 - 8 * r - c] = x[s + 56 - 8 * c];
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        int          s;
        y = '0;
        for (int r = 0; r < 8; r++) begin
            s = (r < 4) ? (2 * r + 1) : (2 * r - 8);
            for (int c = 0; c < 8; c++) begin
                y[s + 56 - 8 * c] = x[63 - 8 * r - c];
            end
        end
        return y;
    endfunction

    logic [63:0]        perm_data;
    logic [STAGES-1:0]  valid_reg;
    logic [63:0]        data_reg [STAGES];
    logic [TAG_W-1:0]   tag_reg  [STAGES];
    logic [STAGES:0]    ready;
    logic [STAGES-1:0]  stage_valid_in;
    logic [63:0]        stage_data_in [STAGES];
    logic [TAG_W-1:0]   stage_tag_in  [STAGES];
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               in_xfer;
    logic               out_xfer;

    always_comb begin
        perm_data = in_data_i;
        case (in_mode_i)
            2'b00:   perm_data = ip_perm(in_data_i);
            2'b01:   perm_data = fp_perm(in_data_i);
            2'b10:   perm_data = fp_perm({in_data_i[31:0], in_data_i[63:32]});
            default: perm_data = in_data_i;
        endcase
    end

    // Ready ripples backwards so a full pipeline still accepts when the sink drains.
    assign ready[STAGES] = out_ready_i;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            assign ready[gi] = !valid_reg[gi] || ready[gi+1];
            if (gi == 0) begin : g_head
                assign stage_valid_in[gi] = in_valid_i;
                assign stage_data_in[gi]  = perm_data;
                assign stage_tag_in[gi]   = in_tag_i;
            end else begin : g_body
                assign stage_valid_in[gi] = valid_reg[gi-1];
                assign stage_data_in[gi]  = data_reg[gi-1];
                assign stage_tag_in[gi]   = tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_reg[k] <= stage_valid_in[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < STAGES; k++) begin
            if (ready[k]) begin
                data_reg[k] <= stage_data_in[k];
                tag_reg[k]  <= stage_tag_in[k];
            end
        end
    end

    assign in_xfer  = in_valid_i && ready[0];
    assign out_xfer = valid_reg[STAGES-1] && out_ready_i;

    always_comb begin
        count_next = count_reg;
        if (in_xfer && !out_xfer && (count_reg != CNT_W'(STAGES))) begin
            count_next = count_reg + 1'b1;
        end else if (out_xfer && !in_xfer && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = valid_reg[STAGES-1];
    assign out_data_o  = data_reg[STAGES-1];
    assign out_tag_o   = tag_reg[STAGES-1];
    assign count_o     = count_reg;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe: a table-driven permutation model predicts every
// accepted word; a negedge monitor checks outputs, stall stability and occupancy.
module tb_des_perm_pipe;

    localparam int STAGES = 3;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = $clog2(STAGES + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic [1:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  count;

    des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mode_i   (in_mode),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_tag_o   (out_tag),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      accepted = 0;
    int      delivered = 0;
    longint  cyc = 0;
    int      rdy_mode = 0;      // 0: ready held 1, 1: held 0, 2: random
    bit      stream_on = 0;
    int      stream_outs = 0;
    int      stream_gaps = 0;
    longint  last_out_cyc = 0;
    int      ip_src[64];
    int      fp_src[64];

    // Output bit k of IP is input bit ip_src[k]; FP uses the inverse lookup.
    function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic [1:0] m);
        logic [63:0] y;
        logic [63:0] sw;
        y  = x;
        sw = {x[31:0], x[63:32]};
        for (int k = 0; k < 64; k++) begin
            if (m == 2'd0) y[k] = x[ip_src[k]];
            else if (m == 2'd1) y[k] = x[fp_src[k]];
            else if (m == 2'd2) y[k] = sw[fp_src[k]];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: occupancy, stall stability, expected-word capture and output comparison.
    initial begin
        logic        stall_prev;
        logic [63:0] data_prev;
        logic [TAG_W-1:0] tag_prev;
        exp_t        e;
        stall_prev = 1'b0;
        data_prev  = '0;
        tag_prev   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                stall_prev = 1'b0;
            end else begin
                chk("count", 64'(count), 64'(sb.size()));
                if (stall_prev) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", out_data, data_prev);
                    chk("hold_tag", 64'(out_tag), 64'(tag_prev));
                end
                if (in_valid && in_ready) begin
                    sb.push_back({ref_perm(in_data, in_mode), in_tag});
                    accepted++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %h tag %0d expected no word", out_data, out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_tag", 64'(out_tag), 64'(e.tag));
                        $display("out  data=%h tag=%0d cycle=%0d", out_data, out_tag, cyc);
                    end
                    delivered++;
                    if (stream_on) begin
                        if (stream_outs > 0 && cyc != last_out_cyc + 1) stream_gaps++;
                        stream_outs++;
                        last_out_cyc = cyc;
                    end
                end
                stall_prev = out_valid && !out_ready;
                data_prev  = out_data;
                tag_prev   = out_tag;
            end
        end
    end

    // Called at posedge+1; holds the word until an edge accepts it.
    task automatic send(input logic [63:0] d, input logic [1:0] m, input logic [TAG_W-1:0] t,
                        output int tries);
        bit acc;
        acc      = 1'b0;
        tries    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    // Single word into an empty pipe with ready held high; checks STAGES-cycle latency.
    task automatic timed(input logic [63:0] d, input logic [1:0] m, input logic [TAG_W-1:0] t,
                         output logic [63:0] got);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        @(negedge clk);
        chk("timed_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge clk);
            chk("latency_early", 64'(out_valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("latency_valid", 64'(out_valid), 64'd1);
        got = out_data;
        $display("word in=%h mode=%0d out=%h", d, m, got);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s_tab[8];
        int          tries;
        int          acc0;
        int          del0;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] z;

        s_tab = '{1, 3, 5, 7, 0, 2, 4, 6};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                ip_src[63 - 8 * r - c] = s_tab[r] + 56 - 8 * c;
        for (int k = 0; k < 64; k++) fp_src[ip_src[k]] = k;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = '0;
        in_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        timed(64'h0000_0000_0000_0002, 2'b00, 4'd1, y);
        chk("ip_bit1", y, 64'h0100_0000_0000_0000);
        timed(64'h0000_0000_0000_0001, 2'b00, 4'd2, y);
        chk("ip_bit0", y, 64'h0000_0000_0100_0000);
        timed(64'h0200_0000_0000_0000, 2'b00, 4'd3, y);
        chk("ip_bit57", y, 64'h8000_0000_0000_0000);
        timed(64'h8000_0000_0000_0000, 2'b01, 4'd4, y);
        chk("fp_bit63", y, 64'h0200_0000_0000_0000);
        timed(64'h0000_0000_8000_0000, 2'b10, 4'd5, y);
        chk("swapfp_bit31", y, 64'h0200_0000_0000_0000);

        for (int i = 0; i < 8; i++) begin
            x = {$urandom, $urandom};
            timed(x, 2'b00, 4'(i), y);
            timed(y, 2'b01, 4'(i), z);
            chk("roundtrip", z, x);
            timed(x, 2'b11, 4'(i), z);
            chk("pass", z, x);
        end

        // Random words, random modes, back to back.
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom}, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), tries);
        drain();

        // Streaming: one word per cycle, no stall, no output gaps.
        stream_on   = 1'b1;
        stream_outs = 0;
        stream_gaps = 0;
        for (int t = 0; t < 16; t++) begin
            send({$urandom, $urandom}, 2'(t % 4), 4'(t), tries);
            chk("stream_no_stall", 64'(tries), 64'd1);
        end
        drain();
        stream_on = 1'b0;
        chk("stream_outs", 64'(stream_outs), 64'd16);
        chk("stream_gaps", 64'(stream_gaps), 64'd0);

        // Backpressure: only STAGES of 5 words get in while the sink is stalled.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        acc0 = accepted;
        del0 = delivered;
        fork
            begin
                int tr;
                for (int i = 0; i < 5; i++)
                    send({$urandom, $urandom}, 2'($urandom_range(0, 3)), 4'(i + 8), tr);
            end
        join_none
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_count", 64'(count), 64'(STAGES));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(accepted - acc0), 64'(STAGES));
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        rdy_mode = 0;
        wait fork;
        drain();
        chk("bp_delivered", 64'(delivered - del0), 64'd5);

        // Random valid/ready toggling against the scoreboard.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            while ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom}, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), tries);
        end
        rdy_mode = 0;
        drain();

        // Reset with two words in flight and a coincident input word.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send(64'hDEAD_BEEF_0000_0001, 2'b11, 4'd14, tries);
        send(64'hDEAD_BEEF_0000_0002, 2'b11, 4'd15, tries);
        del0     = delivered;
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_0003;
        in_mode  = 2'b11;
        in_tag   = 4'd13;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_nothing_out", 64'(delivered - del0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
